acc_12_stream: RTL
==================

# acc_12_stream

Downstream consumer of the 12-bit pipelined integer adder in `float_arith/int`. It takes the adder's sum stream, qualified by a valid strobe that the issuing logic delays to match the adder's fixed latency, and accumulates each group of `ACC_LEN` consecutive sums into one saturating `ACC_W`-bit total. Completed totals are buffered in a small FIFO and leave on a valid/ready interface toward the next neuron stage.

## Interface
- `ACC_LEN`, default 9: sums per group (3x3 kernel window); legal range 1..255.
- `ACC_W`, default 14: accumulator and output width; legal range 12..24.
- `FIFO_DEPTH`, default 4: result FIFO entries; power of two, 2..16.
- `clk_i`  in  1  system clock; one clock domain, all logic on its rising edge.
- `rst_n_i`  in  1  reset, asynchronous and active-low.
- `clr_i`  in  1  synchronous flush of the group count, the accumulator, the FIFO and `overflow_o`.
- `sum_valid_i`  in  1  `data_sum_i` carries a valid sum this cycle.
- `data_sum_i`  in  12  adder sum, treated as unsigned; bits [3:0] are normally zero and are still added.
- `acc_data_o`  out  ACC_W  FIFO head total; 0 when the FIFO is empty.
- `acc_valid_o`  out  1  FIFO is non-empty.
- `acc_ready_i`  in  1  downstream accepts the head entry.
- `fill_o`  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow_o`  out  1  sticky flag: a completed total was dropped because the FIFO was full.

## Operation
- Group counter `cnt` runs 0..ACC_LEN-1.
- A beat is `sum_valid_i`=1 with `clr_i`=0. On each beat:
  - next total = `data_sum_i` zero-extended if `cnt`==0, otherwise sat(acc + `data_sum_i`).
  - sat() clamps to 2^ACC_W-1. Once the total saturates it stays saturated for the rest of the group.
- If `cnt` < ACC_LEN-1 on a beat: `acc` takes the next total and `cnt` increments.
- If `cnt`==ACC_LEN-1 on a beat: the next total is pushed to the FIFO, `cnt` returns to 0 and `acc` becomes don't-care.
  - With ACC_LEN=1, every beat pushes its own sum.
- Cycles without a beat hold `cnt` and `acc`. Gaps inside a group are allowed.
- Pop happens when `acc_valid_o` and `acc_ready_i` are both 1.
- FIFO boundary cases:
  - Push while full with no pop in the same cycle: the total is dropped, `overflow_o` is set and FIFO contents are unchanged. The group counter still wraps.
  - Push and pop in the same cycle while full: both succeed and occupancy is unchanged.
  - Push and pop in the same cycle while empty is not possible, because `acc_valid_o`=0.
- `clr_i`=1:
  - Next cycle: `cnt`=0, `acc`=0, FIFO empty, `overflow_o`=0.
  - A `sum_valid_i` in the same cycle is ignored. A pop in the same cycle is discarded.
- There is no back-pressure toward the adder. The adder pipeline cannot stall, so the issuing logic must respect `fill_o`. `overflow_o` reports any violation.

## Timing
- Reset (async assert, sync release) values:
  - `cnt`=0, `acc`=0, FIFO empty.
  - `acc_valid_o`=0, `acc_data_o`=0, `fill_o`=0, `overflow_o`=0.
- Latency from the final beat of a group in cycle T, FIFO empty: `acc_valid_o`=1 and `acc_data_o`=total in cycle T+1.
- `acc_data_o` is valid whenever `acc_valid_o`=1 and is stable until popped.
- After a pop in cycle T, the next entry (or 0 if empty) appears in cycle T+1.
- Throughput: one sum accepted per cycle, one total per ACC_LEN cycles.
- Reset asserted mid-group or with a non-empty FIFO: all state is lost immediately and outputs take their reset values asynchronously.
- `overflow_o` rises in the cycle after the dropped push.

## Test plan
- Basic group: ACC_LEN=9, ACC_W=14; nine back-to-back beats of 0x010 -> in the cycle after the 9th beat, `acc_valid_o`=1 and `acc_data_o`=0x0090; `fill_o`=1; then `acc_ready_i`=1 -> empty next cycle, `acc_data_o`=0.
- Saturation and gaps: nine beats of 0xFF0 with 2-cycle idle gaps between them -> total 0x3FFF (raw sum 36720 clamped); the next group of nine beats of 0x001 -> 0x0009, confirming the group restarted cleanly.
- Back-pressure and overflow: `acc_ready_i`=0; five groups of nine beats of 0x020, 0x030, 0x040, 0x050, 0x060 -> `fill_o`=4; `overflow_o`=1 after the fifth group; popping yields 0x120, 0x1B0, 0x240, 0x2D0 in order.
- Full with simultaneous push/pop: FIFO holds 4 entries; the last beat of a group arrives in the same cycle as a pop -> `fill_o` stays 4, `overflow_o` stays 0, and the new total is the last entry popped.
- Flush mid-group: five beats of 0x100, then `clr_i`=1 for one cycle with `sum_valid_i`=1 -> FIFO empty, `overflow_o`=0; then nine beats of 0x010 -> 0x0090, with the earlier partial sum discarded.
- Async reset mid-operation: assert `rst_n_i`=0 between clock edges with 2 FIFO entries and `cnt`=4 -> `acc_valid_o`, `acc_data_o`, `fill_o` and `overflow_o` go to 0 before the next edge; after release, a new group of nine 0x010 beats produces 0x0090.

Source files
------------

// File: rtl/acc_12_stream.sv
// Groups ACC_LEN consecutive adder sums into one saturating ACC_W-bit total.
// Completed totals are queued in a small FIFO and leave on a valid/ready port.
module acc_12_stream #(
    parameter int unsigned ACC_LEN    = 9,
    parameter int unsigned ACC_W      = 14,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          clr_i,
    input  logic                          sum_valid_i,
    input  logic [11:0]                   data_sum_i,
    output logic [ACC_W-1:0]              acc_data_o,
    output logic                          acc_valid_o,
    input  logic                          acc_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          overflow_o
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  LastCnt = 8'(ACC_LEN - 1);

    logic [7:0]       r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_fill;
    logic             r_ovf;

    logic             w_beat;
    logic             w_last;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_total;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    always_comb begin
        w_beat  = sum_valid_i && !clr_i;
        w_last  = w_beat && (r_cnt == LastCnt);
        w_base  = (r_cnt == 8'd0) ? '0 : r_acc;
        // One spare bit catches the carry; a saturated acc stays saturated.
        w_sum   = {1'b0, w_base} + (ACC_W + 1)'(data_sum_i);
        w_total = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
        w_full  = (r_fill == (AW + 1)'(FIFO_DEPTH));
        w_pop   = (r_fill != '0) && acc_ready_i && !clr_i;
        w_push  = w_last && (!w_full || w_pop);
        w_drop  = w_last && w_full && !w_pop;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_beat) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
                r_acc <= w_total;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
            r_ovf  <= 1'b0;
        end else if (clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + (AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_fill <= r_fill - (AW + 1)'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers and fill count gate all reads.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_total;
        end
    end

    always_comb begin
        acc_valid_o = (r_fill != '0);
        acc_data_o  = acc_valid_o ? r_mem[r_rptr] : '0;
        fill_o      = r_fill;
        overflow_o  = r_ovf;
    end

endmodule
